// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result bundle between an ALU client and alu_seq.
interface alu_seq_if #(parameter int W = 8);
  logic           in_valid;
  logic           in_ready;
  logic [7:0]     opcode;
  logic           ci;
  logic [W-1:0]   data_rd;
  logic [W-1:0]   data_rr;
  logic           out_valid;
  logic [2*W-1:0] data_o;
  logic           co;
  logic           zo;
  logic           no;
  logic           vo;
  logic           err;
  modport master (
    output in_valid, opcode, ci, data_rd, data_rr,
    input  in_ready, out_valid, data_o, co, zo, no, vo, err
  );
  modport slave (
    input  in_valid, opcode, ci, data_rd, data_rr,
    output in_ready, out_valid, data_o, co, zo, no, vo, err
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: single-cycle ALU with a W-iteration shift-add multiplier.
module alu_seq #(parameter int W = 8) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, MUL} state_t;
  state_t         st;
  logic [2*W-1:0] p;
  logic [W-1:0]   mcand;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   rd, rr, r;
  logic [3:0]     hi;
  logic [W:0]     sum, diff, psum;
  logic [2*W-1:0] p_nx;
  logic           c, v, e, is_mul, acc;
  assign rd       = bus.data_rd;
  assign rr       = bus.data_rr;
  assign hi       = bus.opcode[7:4];
  assign is_mul   = hi == 4'h4;
  assign sum      = {1'b0, rd} + {1'b0, rr} + (W+1)'(hi[0] & bus.ci);
  assign diff     = {1'b0, rd} - {1'b0, rr} - (W+1)'(hi[0] & bus.ci);
  // p holds {partial product, remaining multiplier bits}; shift right each step
  assign psum     = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, mcand} : '0);
  assign p_nx     = {psum, p[W-1:1]};
  assign bus.in_ready = (st == IDLE) && !rst;
  assign acc      = bus.in_valid && bus.in_ready;
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    e = 1'b0;
    case (hi)
      4'h0: begin
        r = bus.opcode[1] ? (bus.opcode[0] ? {bus.ci, rd[W-1:1]} : {rd[W-2:0], bus.ci})
                          : (bus.opcode[0] ? {rd[W-1], rd[W-1:1]} : {rd[W-2:0], 1'b0});
        c = bus.opcode[0] ? rd[0] : rd[W-1];
      end
      4'h4: ;
      4'h8: r = rd & rr;
      4'h9: r = rd | rr;
      4'hA: r = rd ^ rr;
      4'hB: begin
        r = '0 - rd;
        v = rd == {1'b1, {(W-1){1'b0}}};
      end
      4'hC, 4'hD: begin
        r = sum[W-1:0];
        c = sum[W];
        v = (rd[W-1] == rr[W-1]) && (sum[W-1] != rd[W-1]);
      end
      4'hE, 4'hF: begin
        r = diff[W-1:0];
        c = diff[W];
        v = (rd[W-1] != rr[W-1]) && (diff[W-1] != rd[W-1]);
      end
      default: e = 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.data_o    <= '0;
      bus.co        <= 1'b0;
      bus.zo        <= 1'b0;
      bus.no        <= 1'b0;
      bus.vo        <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (st == MUL) begin
        p   <= p_nx;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          st            <= IDLE;
          cnt           <= '0;
          bus.out_valid <= 1'b1;
          bus.data_o    <= p_nx;
          bus.co        <= p_nx[2*W-1];
          bus.zo        <= p_nx == '0;
          bus.no        <= 1'b0;
          bus.vo        <= 1'b0;
          bus.err       <= 1'b0;
        end
      end else if (acc) begin
        if (is_mul) begin
          st    <= MUL;
          p     <= {{W{1'b0}}, rr};
          mcand <= rd;
        end else begin
          bus.out_valid <= 1'b1;
          bus.data_o    <= {{W{1'b0}}, r};
          bus.co        <= c;
          bus.zo        <= r == '0;
          bus.no        <= r[W-1];
          bus.vo        <= v;
          bus.err       <= e;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq at W=8.
module tb_alu_seq;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_fail = 0, leak = 0, lat, nv;
  always #5 clk = ~clk;
  alu_seq_if #(.W(W)) bus();
  alu_seq #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // exp = {err, vo, no, zo, co, data[15:0]}
  task automatic check_res(input string tag, input logic [20:0] exp);
    check({tag, ".data"}, bus.data_o, exp[15:0]);
    check({tag, ".co"},   bus.co,     exp[16]);
    check({tag, ".zo"},   bus.zo,     exp[17]);
    check({tag, ".no"},   bus.no,     exp[18]);
    check({tag, ".vo"},   bus.vo,     exp[19]);
    check({tag, ".err"},  bus.err,    exp[20]);
  endtask
  task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, output int l);
    int k;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("ready_wait", bus.in_ready, 1'b1);
    bus.opcode  = op;
    bus.data_rd = a;
    bus.data_rr = b;
    bus.ci      = c;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (!bus.out_valid && bus.in_ready) leak++;
    end while (!bus.out_valid && l < 40);
  endtask
  function automatic logic [20:0] model(input logic [7:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic c);
    logic [15:0] r;
    logic        co, vo, er;
    int          t, s, cin;
    r = '0; co = 0; vo = 0; er = 0;
    cin = op[4] ? int'(c) : 0;
    case (op[7:4])
      4'h0: case (op[1:0])
        2'd0: begin r = {8'h0, a[6:0], 1'b0}; co = a[7]; end
        2'd1: begin r = {8'h0, a[7], a[7:1]}; co = a[0]; end
        2'd2: begin r = {8'h0, a[6:0], c};    co = a[7]; end
        default: begin r = {8'h0, c, a[7:1]}; co = a[0]; end
      endcase
      4'h4: begin t = int'(a) * int'(b); r = 16'(t); co = r[15]; end
      4'h8: r = {8'h0, a & b};
      4'h9: r = {8'h0, a | b};
      4'hA: r = {8'h0, a ^ b};
      4'hB: begin r = 16'((256 - int'(a)) % 256); vo = a == 8'h80; end
      4'hC, 4'hD: begin
        t = int'(a) + int'(b) + cin; co = t > 255; r = 16'(t % 256);
        s = int'($signed(a)) + int'($signed(b)) + cin; vo = s > 127 || s < -128;
      end
      4'hE, 4'hF: begin
        t = int'(a) - int'(b) - cin; co = t < 0; r = 16'((t + 256) % 256);
        s = int'($signed(a)) - int'($signed(b)) - cin; vo = s > 127 || s < -128;
      end
      default: er = 1'b1;
    endcase
    return {er, vo, (op[7:4] == 4'h4) ? 1'b0 : r[7], r == 16'h0, co, r};
  endfunction
  initial begin
    logic [7:0] ops [13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h40, 8'h80, 8'h90,
                             8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hE0, 8'hF0};
    logic [7:0] op, a, b;
    logic       c;
    bus.in_valid = 0; bus.opcode = 0; bus.ci = 0; bus.data_rd = 0; bus.data_rr = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", bus.in_ready, 1'b0);
    check("rst_ov", bus.out_valid, 1'b0);
    check_res("rst", 21'h0);
    rst = 1'b0;
    #1 check("ready_after_rst", bus.in_ready, 1'b1);
    @(negedge clk);
    issue(8'h40, 8'd45, 8'd84, 1'b0, lat);
    check("mul_lat", lat, 9);
    check("mul_leak", leak, 0);
    check_res("mul", {5'b00000, 16'h0EC4});
    issue(8'hC0, 8'd35, 8'd84, 1'b0, lat);
    check("add_lat", lat, 1);
    check_res("add", {5'b00000, 16'h0077});
    @(negedge clk);
    check("hold_ov", bus.out_valid, 1'b0);
    check("hold_data", bus.data_o, 16'h0077);
    issue(8'hE0, 8'd35, 8'd84, 1'b0, lat);
    check_res("sub_neg", {5'b00101, 16'h00CF});
    issue(8'hE0, 8'd35, 8'd35, 1'b0, lat);
    check_res("sub_zero", {5'b00010, 16'h0000});
    issue(8'hC0, 8'd127, 8'd1, 1'b0, lat);
    check_res("add_ovf", {5'b01100, 16'h0080});
    issue(8'hB0, 8'h80, 8'h00, 1'b0, lat);
    check_res("neg_min", {5'b01100, 16'h0080});
    issue(8'h01, 8'h96, 8'h00, 1'b0, lat);
    check_res("asr", {5'b00100, 16'h00CB});
    issue(8'h02, 8'h81, 8'h00, 1'b0, lat);
    check_res("rol", {5'b00001, 16'h0002});
    issue(8'hD0, 8'hFF, 8'h00, 1'b1, lat);
    check_res("addc_wrap", {5'b00011, 16'h0000});
    issue(8'hF0, 8'h10, 8'h0F, 1'b1, lat);
    check_res("subc_zero", {5'b00010, 16'h0000});
    issue(8'h20, 8'h12, 8'h34, 1'b0, lat);
    check("undef_lat", lat, 1);
    check_res("undef", {5'b10010, 16'h0000});
    bus.data_rd = 8'hF0; bus.data_rr = 8'h3C; bus.ci = 0;
    bus.opcode = 8'h80; bus.in_valid = 1'b1;
    @(negedge clk);
    check("b2b_and_ov", bus.out_valid, 1'b1);
    check("b2b_and", bus.data_o, 16'h0030);
    bus.opcode = 8'h90;
    @(negedge clk);
    check("b2b_or_ov", bus.out_valid, 1'b1);
    check("b2b_or", bus.data_o, 16'h00FC);
    bus.opcode = 8'hA0;
    @(negedge clk);
    check("b2b_xor_ov", bus.out_valid, 1'b1);
    check("b2b_xor", bus.data_o, 16'h00CC);
    bus.in_valid = 1'b0;
    bus.opcode = 8'h40; bus.data_rd = 8'd200; bus.data_rr = 8'd100; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("abort_rst_ready", bus.in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("abort_ov", bus.out_valid, 1'b0);
    check_res("abort", 21'h0);
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
    end
    check("abort_no_pulse", nv, 0);
    issue(8'hC0, 8'd10, 8'd20, 1'b0, lat);
    check_res("post_abort_add", {5'b00000, 16'h001E});
    leak = 0;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom) : ops[$urandom_range(0, 12)];
      a  = 8'($urandom);
      b  = 8'($urandom);
      c  = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(op, a, b, c, lat);
      check($sformatf("rnd%0d_lat", i), lat, (op[7:4] == 4'h4) ? 9 : 1);
      check_res($sformatf("rnd%0d_op%0h", i, op), model(op, a, b, c));
    end
    check("rnd_leak", leak, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
